// File: rtl/cdbus_pkg.sv
// cdbus_pkg: CSR port widths and arbiter state type shared by the cdbus glue logic.
package cdbus_pkg;
  localparam int CDBUS_CSR_ADDR_W = 5;
  localparam int CDBUS_CSR_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} csr_arb_state_t;
endpackage

// File: rtl/cdbus_rr_pick.sv
// cdbus_rr_pick: N-way round-robin picker; the scan starts at the requester after last.
module cdbus_rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int k;
  // Walk from the farthest offset inward so the nearest requester after last wins.
  always_comb begin
    grant = '0;
    idx = '0;
    k = 0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(last) + i) % N;
      if (valid[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/cdbus_csr_arb.sv
// cdbus_csr_arb: round-robin arbiter sharing one cdbus CSR port between N_REQ requesters.
module cdbus_csr_arb
  import cdbus_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = CDBUS_CSR_ADDR_W,
  parameter int DATA_W = CDBUS_CSR_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       csr_address,
  output logic                    csr_read,
  output logic                    csr_write,
  output logic [DATA_W-1:0]       csr_writedata,
  input  logic [DATA_W-1:0]       csr_readdata
);
  localparam int IW = $clog2(N_REQ);
  csr_arb_state_t state, state_nx;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0] idx, last, owner;
  logic op, accept, rd_done;
  logic [1:0] cnt;

  cdbus_rr_pick #(.N(N_REQ)) u_pick (
    .valid(req_valid),
    .last (last),
    .grant(grant),
    .idx  (idx)
  );

  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign accept = |req_ready;
  assign busy = state != IDLE;
  assign csr_read = state == ISSUE && !op;
  assign csr_write = state == ISSUE && op;
  assign rd_done = state == WAIT && cnt == 2'(RD_LAT - 1);

  always_comb begin
    state_nx = state;
    if (state == IDLE && accept) state_nx = ISSUE;
    if (state == ISSUE) state_nx = op ? IDLE : WAIT;
    if (rd_done) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last <= IW'(N_REQ - 1);
      owner <= '0;
      op <= 1'b0;
      cnt <= '0;
      csr_address <= '0;
      csr_writedata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == WAIT) ? cnt + 2'd1 : 2'd0;
      rsp_valid <= (csr_write || rd_done) ? N_REQ'(1) << owner : '0;
      if (rd_done) rsp_rdata <= csr_readdata;
      if (accept) begin
        last <= idx;
        owner <= idx;
        op <= req_write[idx];
        csr_address <= req_addr[idx*ADDR_W +: ADDR_W];
        csr_writedata <= req_wdata[idx*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_cdbus_csr_arb.sv
// tb_cdbus_csr_arb: directed vector table on a 2-requester arbiter, plus sequences and
// random traffic on a 3-requester, RD_LAT=3 arbiter checked against a timeline model.
module tb_cdbus_csr_arb;
  localparam int NB = 3;
  localparam int RB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] a_valid, a_write, a_ready, a_rsv;
  logic [9:0] a_addr;
  logic [15:0] a_wdata;
  logic [7:0] a_rdata, a_cwd, a_rin;
  logic [4:0] a_caddr;
  logic a_busy, a_rd, a_wr;

  logic [2:0] b_valid, b_write, b_ready, b_rsv;
  logic [14:0] b_addr;
  logic [23:0] b_wdata;
  logic [7:0] b_rdata, b_cwd, b_rin;
  logic [4:0] b_caddr;
  logic b_busy, b_rd, b_wr;

  cdbus_csr_arb #(.N_REQ(2), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_ready(a_ready), .rsp_valid(a_rsv),
    .rsp_rdata(a_rdata), .busy(a_busy), .csr_address(a_caddr), .csr_read(a_rd),
    .csr_write(a_wr), .csr_writedata(a_cwd), .csr_readdata(a_rin)
  );

  cdbus_csr_arb #(.N_REQ(NB), .RD_LAT(RB)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_ready(b_ready), .rsp_valid(b_rsv),
    .rsp_rdata(b_rdata), .busy(b_busy), .csr_address(b_caddr), .csr_read(b_rd),
    .csr_write(b_wr), .csr_writedata(b_cwd), .csr_readdata(b_rin)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
  endtask

  // Timeline model for dut_b: each accepted transaction books its strobe and response cycles.
  int cyc, m_last, free_at, s_cyc, r_cyc, r_owner;
  logic s_op, r_rd;
  logic [4:0] s_addr, cur_addr;
  logic [7:0] s_wd, r_data, cur_wd, cur_rdata;

  function automatic logic [7:0] rdf(input int c);
    return 8'(c * 37 + 11);
  endfunction

  function automatic int oh2i(input logic [2:0] x);
    for (int i = 0; i < 3; i++) if (x == 3'(1 << i)) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_last = NB - 1;
    free_at = cyc;
    s_cyc = -1;
    r_cyc = -1;
    r_rd = 1'b0;
    r_owner = 0;
    cur_addr = '0;
    cur_wd = '0;
    cur_rdata = '0;
  endfunction

  task automatic step_b(input logic [2:0] v, input logic [2:0] w, input logic [14:0] a,
                        input logic [23:0] d, output logic [2:0] rdy_seen);
    int win;
    logic [2:0] exp_rdy, exp_rsv;
    @(negedge clk);
    b_valid = v;
    b_write = w;
    b_addr = a;
    b_wdata = d;
    b_rin = rdf(cyc);
    #1;
    if (cyc == s_cyc) begin
      cur_addr = s_addr;
      cur_wd = s_wd;
    end
    if (cyc == r_cyc && r_rd) cur_rdata = r_data;
    win = -1;
    if (cyc >= free_at)
      for (int i = 1; i <= NB && win < 0; i++) if (v[(m_last + i) % NB]) win = (m_last + i) % NB;
    exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
    exp_rsv = (cyc == r_cyc) ? 3'(1 << r_owner) : 3'b000;
    check("b_cycle",
          32'({b_ready, b_rsv, b_rdata, b_busy, b_caddr, b_rd, b_wr, b_cwd}),
          32'({exp_rdy, exp_rsv, cur_rdata, cyc < free_at, cur_addr,
               cyc == s_cyc && !s_op, cyc == s_cyc && s_op, cur_wd}));
    if (win >= 0) begin
      m_last = win;
      s_cyc = cyc + 1;
      s_op = w[win];
      s_addr = a[win*5 +: 5];
      s_wd = d[win*8 +: 8];
      r_owner = win;
      r_rd = !w[win];
      r_cyc = cyc + 2 + (w[win] ? 0 : RB);
      r_data = rdf(cyc + 1 + RB);
      free_at = r_cyc;
    end
    rdy_seen = b_ready;
    cyc++;
  endtask

  typedef struct {
    logic [1:0] v, w;
    logic [4:0] a0, a1;
    logic [7:0] d0, d1, rin;
    logic [1:0] rdy;
    logic rd, wr;
    logic [4:0] addr;
    logic [7:0] wd;
    logic [1:0] rsv;
    logic [7:0] rdata;
    logic busy;
  } vec_t;

  vec_t tab[15];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0] r;
    int ng, rsp_at, rdy_at, nrsp;
    tab[0]  = '{2'b01, 2'b01, 5'h03, 5'h00, 8'hA5, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 5'h00, 8'h00, 2'b00, 8'h00, 1'b0};
    tab[1]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 5'h03, 8'hA5, 2'b00, 8'h00, 1'b1};
    tab[2]  = '{2'b10, 2'b00, 5'h00, 5'h10, 8'h00, 8'h77, 8'h00, 2'b10, 1'b0, 1'b0, 5'h03, 8'hA5, 2'b01, 8'h00, 1'b0};
    tab[3]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 5'h10, 8'h77, 2'b00, 8'h00, 1'b1};
    tab[4]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h5C, 2'b00, 1'b0, 1'b0, 5'h10, 8'h77, 2'b00, 8'h00, 1'b1};
    tab[5]  = '{2'b01, 2'b01, 5'h07, 5'h00, 8'h3C, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 5'h10, 8'h77, 2'b10, 8'h5C, 1'b0};
    tab[6]  = '{2'b10, 2'b10, 5'h00, 5'h1F, 8'h00, 8'hEE, 8'h00, 2'b00, 1'b0, 1'b1, 5'h07, 8'h3C, 2'b00, 8'h5C, 1'b1};
    tab[7]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'h07, 8'h3C, 2'b01, 8'h5C, 1'b0};
    tab[8]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'h07, 8'h3C, 2'b00, 8'h5C, 1'b0};
    tab[9]  = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'h07, 8'h3C, 2'b00, 8'h5C, 1'b0};
    tab[10] = '{2'b11, 2'b11, 5'h01, 5'h02, 8'h11, 8'h22, 8'h00, 2'b10, 1'b0, 1'b0, 5'h07, 8'h3C, 2'b00, 8'h5C, 1'b0};
    tab[11] = '{2'b11, 2'b11, 5'h01, 5'h02, 8'h11, 8'h22, 8'h00, 2'b00, 1'b0, 1'b1, 5'h02, 8'h22, 2'b00, 8'h5C, 1'b1};
    tab[12] = '{2'b11, 2'b11, 5'h01, 5'h02, 8'h11, 8'h22, 8'h00, 2'b01, 1'b0, 1'b0, 5'h02, 8'h22, 2'b10, 8'h5C, 1'b0};
    tab[13] = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 5'h01, 8'h11, 2'b00, 8'h5C, 1'b1};
    tab[14] = '{2'b00, 2'b00, 5'h00, 5'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 5'h01, 8'h11, 2'b01, 8'h5C, 1'b0};

    a_valid = 2'b11; a_write = '0; a_addr = '0; a_wdata = '0; a_rin = '0;
    b_valid = 3'b111; b_write = '0; b_addr = '0; b_wdata = '0; b_rin = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_a", 32'({a_ready, a_rsv, a_rdata, a_busy, a_caddr, a_rd, a_wr, a_cwd}), 32'd0);
    check("reset_b", 32'({b_ready, b_rsv, b_rdata, b_busy, b_caddr, b_rd, b_wr, b_cwd}), 32'd0);
    a_valid = '0;
    b_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    foreach (tab[i]) begin
      @(negedge clk);
      a_valid = tab[i].v;
      a_write = tab[i].w;
      a_addr = {tab[i].a1, tab[i].a0};
      a_wdata = {tab[i].d1, tab[i].d0};
      a_rin = tab[i].rin;
      #1;
      check($sformatf("vec%0d", i),
            32'({a_ready, a_rsv, a_rdata, a_busy, a_caddr, a_rd, a_wr, a_cwd}),
            32'({tab[i].rdy, tab[i].rsv, tab[i].rdata, tab[i].busy, tab[i].addr,
                 tab[i].rd, tab[i].wr, tab[i].wd}));
    end

    ng = 0;
    for (int i = 0; i < 12; i++) begin
      step_b(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {8'h33, 8'h22, 8'h11}, r);
      if (r != 0) begin
        check("rot_grant", 32'(oh2i(r)), 32'(ng % NB));
        ng++;
      end
    end
    check("rot_count", 32'(ng), 32'd6);
    repeat (3) step_b(3'b000, 3'b000, '0, '0, r);

    step_b(3'b001, 3'b000, {5'd0, 5'd0, 5'h0A}, 24'h0, r);
    rsp_at = -1;
    rdy_at = -1;
    for (int k = 1; k < 10; k++) begin
      step_b(3'b010, 3'b010, {5'd0, 5'h0B, 5'd0}, {8'h0, 8'h5A, 8'h0}, r);
      if (b_rsv[0] && rsp_at < 0) rsp_at = k;
      if (r[1] && rdy_at < 0) rdy_at = k;
    end
    check("pend_rsp", 32'(rsp_at), 32'(2 + RB));
    check("pend_accept", 32'(rdy_at), 32'(2 + RB));
    repeat (3) step_b(3'b000, 3'b000, '0, '0, r);

    step_b(3'b001, 3'b000, {5'd0, 5'd0, 5'h0C}, 24'h0, r);
    step_b(3'b000, 3'b000, '0, '0, r);
    step_b(3'b000, 3'b000, '0, '0, r);
    @(negedge clk);
    b_valid = 3'b111;
    reset = 1'b1;
    #1;
    check("reset_wait", 32'({b_ready, b_rsv, b_rdata, b_busy, b_caddr, b_rd, b_wr, b_cwd}), 32'd0);
    @(negedge clk);
    b_valid = '0;
    reset = 1'b0;
    model_reset();
    nrsp = 0;
    repeat (8) begin
      step_b(3'b000, 3'b000, '0, '0, r);
      if (b_rsv != 0) nrsp++;
    end
    check("reset_no_rsp", 32'(nrsp), 32'd0);
    step_b(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {8'h33, 8'h22, 8'h11}, r);
    check("reset_first", 32'(r), 32'b001);
    repeat (3) step_b(3'b000, 3'b000, '0, '0, r);

    for (int i = 0; i < 600; i++)
      step_b(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom), 3'($urandom),
             15'($urandom), 24'($urandom), r);
    repeat (8) step_b(3'b000, 3'b000, '0, '0, r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cdbus_csr_arb.md
# cdbus_csr_arb

Round-robin arbiter sharing the single CSR port of one `cdbus` controller between `N_REQ` requesters, such as a host CPU bridge and an auto-configuration/DMA engine. It accepts one transaction at a time on a valid/ready request channel, issues exactly one `csr_read` or `csr_write` strobe to the controller, and returns a single-cycle response to the owning requester. It sits between the system interconnect and the `csr_*` pins of a `cdbus` instance.

## Interface
- `N_REQ`, 2: number of requesters; 2..8.
- `ADDR_W`, 5: CSR address width; must match `cdbus`.
- `DATA_W`, 8: CSR data width; must match `cdbus`.
- `RD_LAT`, 1: cycles from the `csr_read` strobe to `csr_readdata` being valid; 1..4.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: sole clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_write` in N_REQ: 1 = write, 0 = read.
- `req_addr` in N_REQ*ADDR_W: packed; requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_wdata` in N_REQ*DATA_W: packed, same scheme.
- `req_ready` out N_REQ: one-hot or zero; accept strobe.
- `rsp_valid` out N_REQ: one-hot or zero; single-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data; valid when any `rsp_valid` is high.
- `busy` out 1: a transaction is in flight.
- `csr_address` out ADDR_W: to `cdbus`.
- `csr_read` out 1: to `cdbus`.
- `csr_write` out 1: to `cdbus`.
- `csr_writedata` out DATA_W: to `cdbus`.
- `csr_readdata` in DATA_W: from `cdbus`.

## Operation
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE → IDLE for writes; ISSUE → WAIT for reads.
  - WAIT counts `RD_LAT` cycles, then → IDLE.
- Accept happens in IDLE only. The arbiter picks the first requester with `req_valid` set, scanning from `last+1` modulo `N_REQ`. `req_ready[winner]` is combinational and high in that same cycle. On the accept edge, `last`, the owner, op, addr and wdata are latched.
- ISSUE lasts exactly one cycle:
  - `csr_read` or `csr_write` = 1.
  - `csr_address` and `csr_writedata` = latched values.
- `csr_address` and `csr_writedata` hold their last values outside ISSUE. Strobes are 0 outside ISSUE.
- Write completion: `rsp_valid[owner]` pulses in the cycle after ISSUE. `rsp_rdata` holds its previous value.
- Read completion: `csr_readdata` is captured `RD_LAT` cycles after ISSUE. `rsp_valid[owner]` and `rsp_rdata` are presented in the following cycle.
- The response cycle is spent in IDLE, so a new accept can occur in the same cycle as `rsp_valid`.
- A requester may drop `req_valid` before it sees `req_ready`; nothing is committed until the accept. Request fields are sampled only at the accept.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - `last` = N_REQ-1, so requester 0 has top priority.
  - State = IDLE.
- `req_ready` is forced to 0 while `reset` is high.
- Write, with accept at T:
  - strobe at T+1.
  - `rsp_valid` at T+2.
  - next accept possible at T+2 (2-cycle throughput).
- Read, with accept at T:
  - strobe at T+1.
  - data sampled at T+1+RD_LAT.
  - `rsp_valid` at T+2+RD_LAT.
- Simultaneous requests: exactly one winner. With all requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0.
- Wrap-around: with `last` = N_REQ-1, the scan starts at 0.
- Reset mid-transaction: the in-flight transaction is dropped; no `rsp_valid` is ever issued for it. A strobe already driven to `cdbus` is not retracted.
- No combinational path from `csr_readdata` to any output.

## Structure
- Package `cdbus_pkg`:
  - `CDBUS_CSR_ADDR_W` = 5
  - `CDBUS_CSR_DATA_W` = 8
  - enum `csr_arb_state_t` {IDLE, ISSUE, WAIT}
- Sub-module `cdbus_rr_pick`: parameterised N-way round-robin picker. Inputs are `valid` and `last`; outputs are a one-hot `grant` and its index.
- RTL is roughly 150–250 lines in total.

## Test plan
- Single write, req 0, addr 5'h03, data 8'hA5, RD_LAT=1 → `req_ready[0]` at T, `csr_write`=1 with addr 03/data A5 at T+1 only, `rsp_valid`=2'b01 at T+2.
- Single read, req 1, addr 5'h10, `cdbus` returns 8'h5C one cycle after the strobe (RD_LAT=1) → `csr_read` at T+1, `rsp_valid`=2'b10 with `rsp_rdata`=8'h5C at T+3.
- N_REQ=3, all three valid continuously with writes → grant order 0,1,2,0,1,2; one strobe every 2 cycles; never two `req_ready` bits high together.
- Read with RD_LAT=3 from req 0 while req 1 is pending → no accept for req 1 until req 0's `rsp_valid` cycle; req 1 is accepted in that same cycle.
- Reset asserted during WAIT → all outputs 0 immediately; no `rsp_valid` after release; the first accept goes to req 0.
- Req 1 raises `req_valid` then drops it while req 0 owns the bus → req 1 is never granted, and no spurious strobe or `rsp_valid` occurs.
